// File: rtl/tank_bullet_if.sv
// Bullet/hit link between the tank bullet controller (master) and the brick map (slave).
// The map reads the bullet box and returns hit flags that are sampled only on refresh_tick.
interface tank_bullet_if;
  logic [9:0] x_bullet_l;
  logic [9:0] x_bullet_r;
  logic [9:0] y_bullet_t;
  logic [9:0] y_bullet_b;
  logic       hit;
  logic       hit_target;

  modport master (
    output x_bullet_l, x_bullet_r, y_bullet_t, y_bullet_b,
    input  hit, hit_target
  );

  modport slave (
    input  x_bullet_l, x_bullet_r, y_bullet_t, y_bullet_b,
    output hit, hit_target
  );
endinterface

// File: rtl/tank_bullet.sv
// Player tank bullet: launch on fire edge, fly one step per refresh_tick, explode on hit/wall, then park.
// Box updates the clk after the launch/move tick; no backpressure, fire edges outside IDLE are dropped.
module tank_bullet #(
  parameter int BULLET_SIZE   = 4,
  parameter int BULLET_SPEED  = 4,
  parameter int EXPLODE_TICKS = 8,
  parameter int X_MIN         = 32,
  parameter int X_MAX         = 607,
  parameter int Y_MIN         = 32,
  parameter int Y_MAX         = 447,
  parameter int PARK          = 1020
) (
  input  logic                 clk_50MHz,
  input  logic                 reset,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic                 refresh_tick,
  input  logic                 fire,
  input  logic [1:0]           dir,
  input  logic [9:0]           x_tank_l,
  input  logic [9:0]           x_tank_r,
  input  logic [9:0]           y_tank_t,
  input  logic [9:0]           y_tank_b,
  tank_bullet_if.master        bus,
  output logic                 bullet_active,
  output logic                 bullet_on,
  output logic                 explode_on,
  output logic [7:0]           shot_count
);

  typedef enum logic [1:0] {IDLE, FLYING, EXPLODE} state_t;

  localparam logic [10:0] SZ       = 11'(BULLET_SIZE);
  localparam logic [10:0] HALF     = 11'(BULLET_SIZE / 2);
  localparam logic [10:0] SPD      = 11'(BULLET_SPEED);
  localparam logic [10:0] XMIN     = 11'(X_MIN);
  localparam logic [10:0] XMAX     = 11'(X_MAX);
  localparam logic [10:0] YMIN     = 11'(Y_MIN);
  localparam logic [10:0] YMAX     = 11'(Y_MAX);
  localparam logic [10:0] PARK_C   = 11'(PARK);
  localparam logic [10:0] ONE      = 11'd1;
  localparam logic [10:0] PAD      = 11'((8 - BULLET_SIZE) / 2);
  localparam logic [10:0] SCR_MAX  = 11'd1023;
  localparam logic [7:0]  EXP_LAST = 8'(EXPLODE_TICKS - 1);

  state_t     state;
  logic [1:0] dir_r;
  logic       fire_q;
  logic       fire_pending;
  logic [7:0] exp_cnt;

  logic [10:0] mx, my;
  logic [10:0] l11, r11, t11, b11;
  logic [10:0] ln_l, ln_t;
  logic [10:0] mv_l, mv_t;
  logic        at_wall;
  logic [10:0] nxt_l, nxt_t;
  logic [10:0] ex_l, ex_r, ex_t, ex_b;
  logic        fire_edge, launch;

  assign l11 = 11'(bus.x_bullet_l);
  assign r11 = 11'(bus.x_bullet_r);
  assign t11 = 11'(bus.y_bullet_t);
  assign b11 = 11'(bus.y_bullet_b);

  assign fire_edge = fire & ~fire_q;
  assign launch    = (state == IDLE) && refresh_tick && fire_pending;

  // Launch point sits just outside the tank face, centred on the tank.
  always_comb begin
    mx   = (11'(x_tank_l) + 11'(x_tank_r)) >> 1;
    my   = (11'(y_tank_t) + 11'(y_tank_b)) >> 1;
    ln_l = mx - HALF;
    ln_t = my - HALF;
    case (dir)
      2'b00:   ln_t = 11'(y_tank_t) - SZ;
      2'b01:   ln_t = 11'(y_tank_b) + ONE;
      2'b10:   ln_l = 11'(x_tank_l) - SZ;
      default: ln_l = 11'(x_tank_r) + ONE;
    endcase
  end

  // Wall tests are rearranged to avoid subtracting below zero.
  always_comb begin
    mv_l    = l11;
    mv_t    = t11;
    at_wall = 1'b0;
    case (dir_r)
      2'b00: begin
        at_wall = t11 < (YMIN + SPD);
        mv_t    = at_wall ? YMIN : (t11 - SPD);
      end
      2'b01: begin
        at_wall = (b11 + SPD) > YMAX;
        mv_t    = at_wall ? (YMAX - SZ + ONE) : (t11 + SPD);
      end
      2'b10: begin
        at_wall = l11 < (XMIN + SPD);
        mv_l    = at_wall ? XMIN : (l11 - SPD);
      end
      default: begin
        at_wall = (r11 + SPD) > XMAX;
        mv_l    = at_wall ? (XMAX - SZ + ONE) : (l11 + SPD);
      end
    endcase
  end

  always_comb begin
    nxt_l = l11;
    nxt_t = t11;
    case (state)
      IDLE: begin
        if (launch) begin
          nxt_l = ln_l;
          nxt_t = ln_t;
        end
      end
      FLYING: begin
        if (refresh_tick && !(bus.hit || bus.hit_target)) begin
          nxt_l = mv_l;
          nxt_t = mv_t;
        end
      end
      EXPLODE: begin
        if (refresh_tick && (exp_cnt == EXP_LAST)) begin
          nxt_l = PARK_C;
          nxt_t = PARK_C;
        end
      end
      default: begin
        nxt_l = PARK_C;
        nxt_t = PARK_C;
      end
    endcase
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      dir_r          <= 2'b00;
      fire_q         <= 1'b0;
      fire_pending   <= 1'b0;
      exp_cnt        <= 8'd0;
      shot_count     <= 8'd0;
      bullet_active  <= 1'b0;
      bus.x_bullet_l <= 10'(PARK_C);
      bus.x_bullet_r <= 10'(PARK_C + SZ - ONE);
      bus.y_bullet_t <= 10'(PARK_C);
      bus.y_bullet_b <= 10'(PARK_C + SZ - ONE);
    end else begin
      fire_q         <= fire;
      bus.x_bullet_l <= 10'(nxt_l);
      bus.x_bullet_r <= 10'(nxt_l + SZ - ONE);
      bus.y_bullet_t <= 10'(nxt_t);
      bus.y_bullet_b <= 10'(nxt_t + SZ - ONE);
      case (state)
        IDLE: begin
          if (launch) begin
            dir_r         <= dir;
            fire_pending  <= 1'b0;
            shot_count    <= shot_count + 8'd1;
            bullet_active <= 1'b1;
            state         <= FLYING;
          end else if (fire_edge) begin
            fire_pending <= 1'b1;
          end
        end
        FLYING: begin
          if (refresh_tick && (bus.hit || bus.hit_target || at_wall)) begin
            bullet_active <= 1'b0;
            state         <= EXPLODE;
          end
        end
        EXPLODE: begin
          if (refresh_tick) begin
            if (exp_cnt == EXP_LAST) begin
              exp_cnt <= 8'd0;
              state   <= IDLE;
            end else begin
              exp_cnt <= exp_cnt + 8'd1;
            end
          end
        end
        default: begin
          bullet_active <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  // Explosion box grows the bullet box by PAD on every side, clipped to the screen range.
  always_comb begin
    ex_l = (l11 >= PAD) ? (l11 - PAD) : 11'd0;
    ex_t = (t11 >= PAD) ? (t11 - PAD) : 11'd0;
    ex_r = ((r11 + PAD) > SCR_MAX) ? SCR_MAX : (r11 + PAD);
    ex_b = ((b11 + PAD) > SCR_MAX) ? SCR_MAX : (b11 + PAD);
  end

  assign bullet_on  = bullet_active &&
                      (x >= bus.x_bullet_l) && (x <= bus.x_bullet_r) &&
                      (y >= bus.y_bullet_t) && (y <= bus.y_bullet_b);

  assign explode_on = (state == EXPLODE) &&
                      (11'(x) >= ex_l) && (11'(x) <= ex_r) &&
                      (11'(y) >= ex_t) && (11'(y) <= ex_b);

endmodule

// File: tb/tb_tank_bullet.sv
// Scoreboard bench for tank_bullet: each refresh tick queues the expected box/state, checked just after the edge.
module tb_tank_bullet;

  logic       clk_50MHz = 1'b0;
  logic       reset;
  logic [9:0] x, y;
  logic       refresh_tick;
  logic       fire;
  logic [1:0] dir;
  logic [9:0] x_tank_l, x_tank_r, y_tank_t, y_tank_b;
  logic       bullet_active, bullet_on, explode_on;
  logic [7:0] shot_count;
  logic       sample_req;

  tank_bullet_if bif ();

  tank_bullet dut (
    .clk_50MHz     (clk_50MHz),
    .reset         (reset),
    .x             (x),
    .y             (y),
    .refresh_tick  (refresh_tick),
    .fire          (fire),
    .dir           (dir),
    .x_tank_l      (x_tank_l),
    .x_tank_r      (x_tank_r),
    .y_tank_t      (y_tank_t),
    .y_tank_b      (y_tank_b),
    .bus           (bif),
    .bullet_active (bullet_active),
    .bullet_on     (bullet_on),
    .explode_on    (explode_on),
    .shot_count    (shot_count)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  typedef struct {
    string tag;
    int    l;
    int    t;
    int    act;
    int    shots;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    n_tests++;
    if (obs != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  always @(posedge clk_50MHz) begin
    if (sample_req) begin
      #1;
      chk("sb_underflow", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".l"},     int'(bif.x_bullet_l), e.l);
        chk({e.tag, ".r"},     int'(bif.x_bullet_r), e.l + 3);
        chk({e.tag, ".t"},     int'(bif.y_bullet_t), e.t);
        chk({e.tag, ".b"},     int'(bif.y_bullet_b), e.t + 3);
        chk({e.tag, ".act"},   int'(bullet_active),  e.act);
        chk({e.tag, ".shots"}, int'(shot_count),     e.shots);
      end
    end
  end

  // hits = {hit_target, hit}, presented only for the tick clk
  task automatic do_tick(input string tag, input int l, input int t, input int act,
                         input int shots, input logic [1:0] hits);
    exp_t ex;
    ex.tag = tag; ex.l = l; ex.t = t; ex.act = act; ex.shots = shots;
    exp_q.push_back(ex);
    @(negedge clk_50MHz);
    refresh_tick   = 1'b1;
    bif.hit        = hits[0];
    bif.hit_target = hits[1];
    sample_req     = 1'b1;
    @(negedge clk_50MHz);
    refresh_tick   = 1'b0;
    bif.hit        = 1'b0;
    bif.hit_target = 1'b0;
    sample_req     = 1'b0;
  endtask

  task automatic fire_pulse();
    @(negedge clk_50MHz);
    fire = 1'b1;
    @(negedge clk_50MHz);
    fire = 1'b0;
  endtask

  task automatic set_tank(input int l, input int r, input int t, input int b);
    x_tank_l = 10'(l); x_tank_r = 10'(r);
    y_tank_t = 10'(t); y_tank_b = 10'(b);
  endtask

  // Eight explosion ticks: held for seven, parked on the eighth.
  task automatic explode_out(input string tag, input int l, input int t, input int shots);
    for (int k = 1; k <= 8; k++) begin
      if (k < 8) do_tick(tag, l, t, 0, shots, 2'b00);
      else       do_tick({tag, "_park"}, 1020, 1020, 0, shots, 2'b00);
    end
  endtask

  task automatic pix(input string tag, input int px, input int py, input int bon, input int eon);
    @(negedge clk_50MHz);
    x = 10'(px); y = 10'(py);
    #1;
    chk({tag, ".bullet_on"},  int'(bullet_on),  bon);
    chk({tag, ".explode_on"}, int'(explode_on), eon);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; x = '0; y = '0; refresh_tick = 1'b0; fire = 1'b0; dir = 2'b00;
    sample_req = 1'b0; bif.hit = 1'b0; bif.hit_target = 1'b0;
    set_tank(288, 319, 400, 431);
    repeat (2) @(negedge clk_50MHz);
    chk("rst.l", int'(bif.x_bullet_l), 1020);
    chk("rst.r", int'(bif.x_bullet_r), 1023);
    chk("rst.t", int'(bif.y_bullet_t), 1020);
    chk("rst.b", int'(bif.y_bullet_b), 1023);
    chk("rst.act", int'(bullet_active), 0);
    chk("rst.shots", int'(shot_count), 0);
    chk("rst.explode_on", int'(explode_on), 0);
    reset = 1'b0;

    // Launch up, step, stray hit without a tick, fire edge in flight, then hit.
    do_tick("idle_no_fire", 1020, 1020, 0, 0, 2'b00);
    fire_pulse();
    do_tick("up_launch", 301, 396, 1, 1, 2'b00);
    do_tick("up_step1", 301, 392, 1, 1, 2'b00);
    pix("pix_in", 302, 393, 1, 0);
    pix("pix_out", 305, 393, 0, 0);
    @(negedge clk_50MHz); bif.hit = 1'b1;
    @(negedge clk_50MHz); bif.hit = 1'b0;
    do_tick("hit_no_tick", 301, 388, 1, 1, 2'b00);
    fire_pulse();
    do_tick("fire_in_flight", 301, 384, 1, 1, 2'b00);
    do_tick("up_hit", 301, 384, 0, 1, 2'b01);
    pix("exp_edge", 299, 382, 0, 1);
    pix("exp_out", 298, 382, 0, 0);
    pix("exp_centre", 302, 385, 0, 1);
    fire_pulse();
    explode_out("up_exp", 301, 384, 1);
    do_tick("no_queued_fire", 1020, 1020, 0, 1, 2'b00);

    // Fire held high across the return to IDLE must not relaunch.
    fire_pulse();
    do_tick("launch2", 301, 396, 1, 2, 2'b00);
    @(negedge clk_50MHz); fire = 1'b1;
    do_tick("hit2", 301, 396, 0, 2, 2'b01);
    explode_out("exp2", 301, 396, 2);
    do_tick("fire_held", 1020, 1020, 0, 2, 2'b00);
    @(negedge clk_50MHz); fire = 1'b0;
    fire_pulse();
    do_tick("launch3", 301, 396, 1, 3, 2'b00);
    for (int k = 1; k <= 24; k++) do_tick("fly_up", 301, 396 - 4 * k, 1, 3, 2'b00);

    // Asynchronous reset with the bullet at t=300.
    #3 reset = 1'b1;
    #1;
    chk("arst.l", int'(bif.x_bullet_l), 1020);
    chk("arst.r", int'(bif.x_bullet_r), 1023);
    chk("arst.t", int'(bif.y_bullet_t), 1020);
    chk("arst.b", int'(bif.y_bullet_b), 1023);
    chk("arst.act", int'(bullet_active), 0);
    chk("arst.shots", int'(shot_count), 0);
    @(negedge clk_50MHz); reset = 1'b0;

    // Right wall clamp; dir input changes mid-flight are ignored.
    set_tank(566, 597, 200, 231); dir = 2'b11;
    fire_pulse();
    do_tick("right_launch", 598, 213, 1, 1, 2'b00);
    dir = 2'b00; set_tank(100, 131, 100, 131);
    do_tick("right_step", 602, 213, 1, 1, 2'b00);
    do_tick("right_clamp", 604, 213, 0, 1, 2'b00);
    explode_out("right_exp", 604, 213, 1);

    // Left wall clamp.
    set_tank(42, 73, 200, 231); dir = 2'b10;
    fire_pulse();
    do_tick("left_launch", 38, 213, 1, 2, 2'b00);
    do_tick("left_step", 34, 213, 1, 2, 2'b00);
    do_tick("left_clamp", 32, 213, 0, 2, 2'b00);
    explode_out("left_exp", 32, 213, 2);

    // Hit and wall crossing on the same tick: explode without the clamp move.
    set_tank(566, 597, 200, 231); dir = 2'b11;
    fire_pulse();
    do_tick("hw_launch", 598, 213, 1, 3, 2'b00);
    do_tick("hw_step", 602, 213, 1, 3, 2'b00);
    do_tick("hw_hit", 602, 213, 0, 3, 2'b01);
    explode_out("hw_exp", 602, 213, 3);

    // Downward launch ended by an enemy-tank hit.
    set_tank(288, 319, 400, 431); dir = 2'b01;
    fire_pulse();
    do_tick("down_launch", 301, 432, 1, 4, 2'b00);
    do_tick("down_step", 301, 436, 1, 4, 2'b00);
    do_tick("down_target", 301, 436, 0, 4, 2'b10);
    explode_out("down_exp", 301, 436, 4);

    repeat (3) @(negedge clk_50MHz);
    chk("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
